uart_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares one UART transmit byte stream among NUM_SRC AXI-Stream requesters.
- Sits in front of the TX-side uart_fifo (m_axis drives the FIFO s_axis).
- A grant is held until the requester ends a packet (tlast) or MAX_BURST beats have been sent, so packets are not interleaved unless they exceed the burst limit.

---
 rtl/uart_tx_arbiter.sv | 106 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one AXI-Stream byte channel (UART TX FIFO input)
// among NUM_SRC requesters; a grant lasts until tlast or MAX_BURST beats.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SRC    = 4,
  parameter int MAX_BURST  = 16,
  localparam int IDW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy
);

  localparam int CNTW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state;
  logic [IDW-1:0]        last_grant;
  logic [IDW-1:0]        sel_idx;
  logic [IDW-1:0]        cand;
  logic                  sel_found;
  logic [CNTW-1:0]       beat_cnt;
  logic [DATA_WIDTH-1:0] src_data [NUM_SRC];
  logic                  beat;
  logic                  release_beat;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Rotating priority: scan starts just after the last source served.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the loop can leave a value held (which would infer a latch).
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand = IDW'((int'(last_grant) + i) % NUM_SRC);
      if (!sel_found && s_axis_tvalid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Pure pass-through of the granted source; no data register on the path.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    if (state == GRANT) begin
      m_axis_tdata            = src_data[grant_id];
      m_axis_tvalid           = s_axis_tvalid[grant_id];
      s_axis_tready[grant_id] = m_axis_tready;
    end
  end

  assign beat         = m_axis_tvalid & m_axis_tready;
  assign release_beat = beat & (s_axis_tlast[grant_id] |
                                (beat_cnt == CNTW'(MAX_BURST - 1)));
  assign busy         = (state == GRANT);

  // A stalled source keeps its grant indefinitely so packets stay contiguous.
  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!aresetn) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= IDW'(NUM_SRC - 1);
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant_id <= sel_idx;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (release_beat) begin
            state      <= IDLE;
            last_grant <= grant_id;
            beat_cnt   <= '0;
          end else if (beat) begin
            beat_cnt <= beat_cnt + CNTW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queue-based sources, a packet-level
// round-robin model producing expected beats, and a decoupled output monitor.
module tb_uart_tx_arbiter;

  localparam int DW  = 8;
  localparam int NS  = 4;
  localparam int MB  = 4;
  localparam int IDW = 2;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [NS*DW-1:0]  s_axis_tdata;
  logic [NS-1:0]     s_axis_tvalid;
  logic [NS-1:0]     s_axis_tlast;
  logic [NS-1:0]     s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [IDW-1:0]    grant_id;
  logic              busy;

  uart_tx_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .MAX_BURST(MB)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    int            src;
    logic [DW-1:0] data;
    bit            rel;
  } exp_t;

  beat_t src_q [NS][$];
  exp_t  exp_q [$];

  int checks = 0;
  int failures = 0;
  int m_last = NS - 1;
  int beats_seen = 0;
  bit chk_idle_next = 1'b0;
  int rdy_mode = 0;
  int pat_idx = 0;
  int stall_at [NS];
  int stall_left [NS];
  int pops_done [NS];
  bit stall_on [NS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int src_left();
    int n = 0;
    for (int i = 0; i < NS; i++) n += src_q[i].size();
    return n;
  endfunction

  task automatic push_pkt(input int s, input int len, input logic [DW-1:0] first, input bit rnd);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = rnd ? DW'($urandom) : first + DW'(k);
      b.last = (k == len - 1);
      src_q[s].push_back(b);
    end
  endtask

  // Reference model: every queued source requests continuously, so grants
  // follow pure round robin over non-empty sources, each grant taking beats
  // until a tlast or MB beats.
  function automatic void build_expected();
    beat_t q [NS][$];
    beat_t b;
    exp_t  e;
    int    s;
    int    c;
    int    n;
    bit    rel;
    for (int i = 0; i < NS; i++) q[i] = src_q[i];
    while (1) begin
      s = -1;
      for (int k = 1; k <= NS; k++) begin
        c = (m_last + k) % NS;
        if (s < 0 && q[c].size() > 0) s = c;
      end
      if (s < 0) break;
      n = 0;
      rel = 1'b0;
      while (!rel && q[s].size() > 0) begin
        b = q[s].pop_front();
        n++;
        rel = b.last || (n == MB);
        e.src = s;
        e.data = b.data;
        e.rel = rel;
        exp_q.push_back(e);
      end
      m_last = s;
    end
  endfunction

  function automatic void flush();
    for (int i = 0; i < NS; i++) begin
      src_q[i].delete();
      stall_at[i] = -1;
      stall_left[i] = 0;
      pops_done[i] = 0;
    end
    exp_q.delete();
    chk_idle_next = 1'b0;
    m_last = NS - 1;
  endfunction

  task automatic drive_inputs();
    bit stalled;
    for (int i = 0; i < NS; i++) begin
      stalled = (stall_at[i] == pops_done[i]) && (stall_left[i] > 0);
      if (stalled) stall_left[i]--;
      stall_on[i] = stalled;
      if (src_q[i].size() > 0 && !stalled) begin
        s_axis_tvalid[i] = 1'b1;
        s_axis_tdata[i*DW +: DW] = src_q[i][0].data;
        s_axis_tlast[i] = src_q[i][0].last;
      end else begin
        s_axis_tvalid[i] = 1'b0;
        s_axis_tdata[i*DW +: DW] = '0;
        s_axis_tlast[i] = 1'b0;
      end
    end
    case (rdy_mode)
      1:       m_axis_tready = ($urandom_range(0, 9) < 7);
      2:       m_axis_tready = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
      default: m_axis_tready = 1'b1;
    endcase
    pat_idx++;
  endtask

  // Source driver: handshakes sampled mid-cycle, applied just after the edge.
  initial begin
    logic [NS-1:0] pm;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b1;
    forever begin
      @(negedge aclk);
      pm = aresetn ? (s_axis_tvalid & s_axis_tready) : '0;
      @(posedge aclk);
      #1;
      if (!aresetn) pm = '0;
      for (int i = 0; i < NS; i++) begin
        if (pm[i] && src_q[i].size() > 0) begin
          void'(src_q[i].pop_front());
          pops_done[i]++;
        end
      end
      drive_inputs();
    end
  end

  // Monitor: compares every output beat and the ready/idle outputs.
  initial begin
    exp_t e;
    int   g;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if (chk_idle_next) begin
          check("bubble_after_release", {31'd0, busy}, 0);
          chk_idle_next = 1'b0;
        end
        if (busy && exp_q.size() > 0) begin
          g = exp_q[0].src;
          check("grant_id", {30'd0, grant_id}, g);
          check("s_tready_track", {28'd0, s_axis_tready}, m_axis_tready ? (1 << g) : 0);
        end else if (busy) begin
          checks++;
          failures++;
          $display("FAIL spurious_grant: got grant_id=%0d with no expected beats", grant_id);
        end else begin
          check("idle_outputs", {19'd0, m_axis_tvalid, s_axis_tready, m_axis_tdata}, 0);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: got data 0x%0h src %0d, required no beat", m_axis_tdata, grant_id);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", {24'd0, m_axis_tdata}, {24'd0, e.data});
            check("beat_src", {30'd0, grant_id}, e.src);
            if (e.rel) chk_idle_next = 1'b1;
            beats_seen++;
          end
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || src_left() != 0) && n < budget) begin
      @(negedge aclk);
      n++;
    end
    check("drain_exp_left", exp_q.size(), 0);
    check("drain_src_left", src_left(), 0);
    repeat (2) @(negedge aclk);
  endtask

  task automatic apply_reset();
    @(negedge aclk);
    #2 aresetn = 1'b0;
    flush();
    repeat (2) @(negedge aclk);
  endtask

  initial begin
    int s;
    int o;
    int seen;
    int n;
    int base;

    // Reset state and a single 3-byte packet from src1
    flush();
    push_pkt(1, 3, 8'h41, 1'b0);
    repeat (3) @(negedge aclk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_grant_id", {30'd0, grant_id}, 0);
    check("rst_m_tvalid", {31'd0, m_axis_tvalid}, 0);
    check("rst_m_tdata", {24'd0, m_axis_tdata}, 0);
    check("rst_s_tready", {28'd0, s_axis_tready}, 0);
    build_expected();
    #2 aresetn = 1'b1;
    @(negedge aclk);
    check("t1_busy", {31'd0, busy}, 1);
    check("t1_grant", {30'd0, grant_id}, 1);
    check("t1_byte0", {23'd0, m_axis_tvalid, m_axis_tdata}, {23'd0, 1'b1, 8'h41});
    @(negedge aclk);
    check("t1_byte1", {23'd0, m_axis_tvalid, m_axis_tdata}, {23'd0, 1'b1, 8'h42});
    @(negedge aclk);
    check("t1_byte2", {23'd0, m_axis_tvalid, m_axis_tdata}, {23'd0, 1'b1, 8'h43});
    @(negedge aclk);
    check("t1_idle", {31'd0, busy}, 0);
    wait_drain(50);

    // Round robin of 1-byte packets straight after reset
    apply_reset();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < NS; i++) push_pkt(i, 1, DW'(16 * i + p), 1'b0);
    build_expected();
    #2 aresetn = 1'b1;
    wait_drain(200);

    // Burst limit: src2 10-byte packet interleaved with src0 packets
    push_pkt(1, 1, 8'h77, 1'b0);
    build_expected();
    wait_drain(50);
    push_pkt(2, 10, 8'hA0, 1'b0);
    push_pkt(0, 2, 8'h50, 1'b0);
    push_pkt(0, 2, 8'h60, 1'b0);
    build_expected();
    wait_drain(200);

    // Backpressure pattern 1,0,0,1 on m_axis_tready
    rdy_mode = 2;
    push_pkt(3, 6, 8'hC0, 1'b0);
    push_pkt(1, 2, 8'hD0, 1'b0);
    build_expected();
    wait_drain(300);
    rdy_mode = 0;

    // Stall hold: granted source drops tvalid for 20 cycles mid-packet
    s = (m_last + 1) % NS;
    o = (s + 2) % NS;
    pops_done[s] = 0;
    stall_at[s] = 1;
    stall_left[s] = 20;
    push_pkt(s, 3, 8'h30, 1'b0);
    push_pkt(o, 2, 8'h90, 1'b0);
    build_expected();
    seen = 0;
    n = 0;
    while (seen < 20 && n < 200) begin
      @(negedge aclk);
      n++;
      if (stall_on[s]) begin
        seen++;
        check("stall_grant", {30'd0, grant_id}, s);
        check("stall_m_tvalid", {31'd0, m_axis_tvalid}, 0);
      end
    end
    check("stall_cycles", seen, 20);
    wait_drain(200);
    stall_at[s] = -1;

    // Reset asserted between edges while the 2nd byte is presented
    push_pkt(1, 3, 8'h11, 1'b0);
    push_pkt(3, 2, 8'h33, 1'b0);
    build_expected();
    base = beats_seen;
    n = 0;
    while (beats_seen < base + 1 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    check("mid_rst_first_beat", beats_seen - base, 1);
    @(posedge aclk);
    #3 aresetn = 1'b0;
    #1;
    check("mid_rst_m_tvalid", {31'd0, m_axis_tvalid}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_s_tready", {28'd0, s_axis_tready}, 0);
    check("mid_rst_grant_id", {30'd0, grant_id}, 0);
    flush();
    push_pkt(3, 1, 8'hE3, 1'b0);
    push_pkt(2, 2, 8'hE2, 1'b0);
    repeat (2) @(negedge aclk);
    build_expected();
    #2 aresetn = 1'b1;
    @(negedge aclk);
    check("post_rst_grant", {30'd0, grant_id}, 2);
    wait_drain(100);

    // Randomized packets with random backpressure
    rdy_mode = 1;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NS; i++) begin
        if ($urandom_range(0, 2) != 0) begin
          n = $urandom_range(1, 3);
          for (int p = 0; p < n; p++) push_pkt(i, $urandom_range(1, 10), 8'h00, 1'b1);
        end
      end
      build_expected();
      wait_drain(3000);
    end
    rdy_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
